factorial_sweep_driver: RTL and testbench

- Sequencer wrapped around the factorial proc: drives its n channel and consumes its result channel.
- On `start`, sweeps n from `cfg_first` to `cfg_last` inclusive, with exactly one request outstanding at a time.
- Accumulates a sum, an XOR and a count of the results, then raises `done`.
- Used as the stimulus/collection front end for the factorial benchmark.

---
 rtl/factorial_pkg.sv | 19 +
 rtl/fact_golden_step.sv | 49 ++++
 rtl/factorial_sweep_driver.sv | 150 +++++++++++++++
 tb/tb_factorial_sweep_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// Shared types and constants for the factorial sweep driver.
package factorial_pkg;

  localparam int FACT_N_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SEND,
    WAIT,
    DONE
  } sweep_state_e;

  // n! mod 256 for n = 0..9; every n >= 10 gives 0.
  localparam logic [0:9][7:0] FACT8 = '{
    8'd1, 8'd1, 8'd2, 8'd6, 8'd24, 8'd120, 8'd208, 8'd176, 8'd128, 8'd128
  };

endpackage

// File: rtl/fact_golden_step.sv
// Running n! mod 2^N_W used to check results. Exists only in builds with
// FACTORIAL_SWEEP_GOLDEN_CHECK_EN defined.
module fact_golden_step #(
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init_i,
  input  logic           step_i,
  input  logic           adv_i,
  input  logic [N_W-1:0] cur_i,
  output logic [N_W-1:0] exp_o,
  output logic           prime_last_o
);

  logic [N_W-1:0] exp_q, exp_d;
  // One bit wider than cur so that k never wraps while it steps up to cur.
  logic [N_W:0]   k_q, k_d;

  always_comb begin
    exp_d = exp_q;
    k_d   = k_q;
    if (init_i) begin
      exp_d = N_W'(1);
      k_d   = (N_W+1)'(1);
    end else if (step_i && (k_q <= {1'b0, cur_i})) begin
      exp_d = exp_q * k_q[N_W-1:0];
      k_d   = k_q + (N_W+1)'(1);
    end else if (adv_i) begin
      exp_d = exp_q * (cur_i + N_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= N_W'(1);
      k_q   <= (N_W+1)'(1);
    end else begin
      exp_q <= exp_d;
      k_q   <= k_d;
    end
  end

  assign exp_o = exp_q;
  // When this is high, the step taken in the current cycle is the last one.
  // The flag is also high at once for cur = 0.
  assign prime_last_o = (k_q >= {1'b0, cur_i});

endmodule

// File: rtl/factorial_sweep_driver.sv
// Sweeps n over [cfg_first, cfg_last] through the factorial proc, one request at a time.
// Accumulates the sum, XOR and count of the results. Define FACTORIAL_SWEEP_GOLDEN_CHECK_EN to add a golden check.
module factorial_sweep_driver
  import factorial_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   cfg_first,
  input  logic [N_W-1:0]   cfg_last,
  output logic [N_W-1:0]   chan_n,
  output logic             chan_n_vld,
  input  logic             chan_n_rdy,
  input  logic [N_W-1:0]   chan_result,
  input  logic             chan_result_vld,
  output logic             chan_result_rdy,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] res_sum,
  output logic [N_W-1:0]   res_xor,
  output logic [N_W-1:0]   res_count,
  output logic             mismatch
);

  sweep_state_e   state_q;
  logic [N_W-1:0] cur_q, last_q, res_xor_q, res_count_q;
  logic [SUM_W-1:0] res_sum_q;
  logic chan_n_vld_q, res_rdy_q, busy_q, done_q;
  logic last_n;

  // cur is compared with last before it is incremented, so the sweep never wraps.
  assign last_n = (cur_q == last_q);

`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
  logic           start_ok, mismatch_q, prime_last;
  logic [N_W-1:0] golden_exp;

  assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));

  fact_golden_step #(.N_W(N_W)) u_golden (
    .clk          (clk),
    .rst          (rst),
    .init_i       (start_ok),
    .step_i       (state_q == PRIME),
    .adv_i        (res_rdy_q & chan_result_vld & ~last_n),
    .cur_i        (cur_q),
    .exp_o        (golden_exp),
    .prime_last_o (prime_last)
  );

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      chan_n_vld_q <= 1'b0;
      res_rdy_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_sum_q    <= '0;
      res_xor_q    <= '0;
      res_count_q  <= '0;
`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
      mismatch_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cur_q       <= cfg_first;
            last_q      <= cfg_last;
            res_sum_q   <= '0;
            res_xor_q   <= '0;
            res_count_q <= '0;
            done_q      <= 1'b0;
`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
            mismatch_q  <= 1'b0;
`endif
            if (cfg_first > cfg_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
              state_q <= PRIME;
`else
              state_q      <= SEND;
              chan_n_vld_q <= 1'b1;
`endif
            end
          end
        end
`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
        PRIME: begin
          if (prime_last) begin
            state_q      <= SEND;
            chan_n_vld_q <= 1'b1;
          end
        end
`endif
        SEND: begin
          if (chan_n_rdy) begin
            state_q      <= WAIT;
            chan_n_vld_q <= 1'b0;
            res_rdy_q    <= 1'b1;
          end
        end
        WAIT: begin
          if (chan_result_vld) begin
            res_sum_q   <= res_sum_q + SUM_W'(chan_result);
            res_xor_q   <= res_xor_q ^ chan_result;
            res_count_q <= res_count_q + N_W'(1);
            res_rdy_q   <= 1'b0;
`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
            if (chan_result != golden_exp) mismatch_q <= 1'b1;
`endif
            if (last_n) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q      <= SEND;
              cur_q        <= cur_q + N_W'(1);
              chan_n_vld_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chan_n          = cur_q;
  assign chan_n_vld      = chan_n_vld_q;
  assign chan_result_rdy = res_rdy_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign res_sum         = res_sum_q;
  assign res_xor         = res_xor_q;
  assign res_count       = res_count_q;

endmodule

// File: tb/tb_factorial_sweep_driver.sv
// Randomized bench for factorial_sweep_driver. A transaction-level model and a factorial responder are checked on every cycle.
module tb_factorial_sweep_driver;
  import factorial_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  cfg_first, cfg_last, chan_n, chan_result, res_xor, res_count;
  logic        chan_n_vld, chan_n_rdy, chan_result_vld, chan_result_rdy;
  logic        busy, done, mismatch;
  logic [15:0] res_sum;

  always #5 clk = ~clk;

  factorial_sweep_driver #(.N_W(8), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .chan_n(chan_n), .chan_n_vld(chan_n_vld), .chan_n_rdy(chan_n_rdy),
    .chan_result(chan_result), .chan_result_vld(chan_result_vld),
    .chan_result_rdy(chan_result_rdy), .busy(busy), .done(done),
    .res_sum(res_sum), .res_xor(res_xor), .res_count(res_count), .mismatch(mismatch)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fact8(input int n);
    int f = 1;
    for (int i = 1; i <= n; i++) f = (f * i) % 256;
    return f[7:0];
  endfunction

`ifdef FACTORIAL_SWEEP_GOLDEN_CHECK_EN
  localparam bit GOLDEN = 1'b1;
`else
  localparam bit GOLDEN = 1'b0;
`endif

  // Sweep model: what the outputs must be after each clock edge.
  bit m_active, m_done, m_req, m_wait, m_mis, armed;
  int m_next, m_last, m_prime, m_sum, m_xor, m_cnt, n_xfers;
  // Factorial responder knobs.
  bit pend, rnd_rdy, px_n, px_r;
  int pend_n, pend_dly, px_nval;
  int hold_n = 0, fix_dly = 0, corrupt_n = -1;

  initial begin
    bit xn, xr;
    int r;
    chan_n_rdy = 1'b1; chan_result_vld = 1'b0; chan_result = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("res_sum", res_sum, m_sum);
        chk("res_xor", res_xor, m_xor);
        chk("res_count", res_count, m_cnt);
        chk("mismatch", mismatch, m_mis);
        chk("n_vld", chan_n_vld, m_req);
        chk("res_rdy", chan_result_rdy, m_wait);
        if (m_req) chk("chan_n", chan_n, m_next);
      end
      // Responder: answers each accepted n after a delay, holding vld/data until taken.
      if (rst) pend = 1'b0;
      else begin
        if (px_r) pend = 1'b0;
        if (px_n) begin
          pend = 1'b1; pend_n = px_nval;
          pend_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
        end
      end
      chan_result_vld = pend && (pend_dly == 0);
      if (pend && pend_dly > 0) pend_dly--;
      if (pend) chan_result = (pend_n == corrupt_n) ? 8'h55 : fact8(pend_n);
      else chan_result = 8'($urandom);
      if (hold_n > 0 && chan_n_vld) begin
        chan_n_rdy = 1'b0; hold_n--;
      end else chan_n_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      // Transfers occurring at the coming edge.
      xn = chan_n_vld & chan_n_rdy;
      xr = chan_result_vld & chan_result_rdy;
      if (rst) begin
        armed = 1'b1;
        m_active = 0; m_done = 0; m_req = 0; m_wait = 0; m_mis = 0;
        m_next = 0; m_prime = 0; m_sum = 0; m_xor = 0; m_cnt = 0;
        px_n = 0; px_r = 0;
      end else begin
        if (!m_active && start) begin
          m_sum = 0; m_xor = 0; m_cnt = 0; m_mis = 0; m_done = 0;
          if (cfg_first > cfg_last) m_done = 1;
          else begin
            m_active = 1; m_wait = 0; m_next = cfg_first; m_last = cfg_last;
            m_prime = GOLDEN ? ((cfg_first == 0) ? 1 : int'(cfg_first)) : 0;
            m_req = (m_prime == 0);
          end
        end else if (m_active) begin
          if (m_prime > 0) begin
            m_prime--;
            if (m_prime == 0) m_req = 1;
          end else if (m_req) begin
            if (xn) begin
              chk("n_seq", chan_n, m_next);
              n_xfers++; m_req = 0; m_wait = 1;
            end
          end else if (m_wait && xr) begin
            r = chan_result;
            m_sum = (m_sum + r) % 65536;
            m_xor = m_xor ^ r;
            m_cnt = (m_cnt + 1) % 256;
            if (GOLDEN && r != fact8(m_next)) m_mis = 1;
            m_wait = 0;
            if (m_next == m_last) begin
              m_active = 0; m_done = 1;
            end else begin
              m_next++; m_req = 1;
            end
          end
        end
        px_n = xn; px_nval = chan_n; px_r = xr;
      end
    end
  end

  task automatic pulse_start(input int f, input int l);
    @(posedge clk); #1;
    cfg_first = 8'(f); cfg_last = 8'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    int n0, f, l;
    rst = 1'b1; start = 1'b0; cfg_first = '0; cfg_last = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_chan_n", chan_n, 0);
    chk("rst_vld", chan_n_vld, 0);
    chk("rst_rdy", chan_result_rdy, 0);
    chk("rst_done", done, 0);
    for (int i = 0; i < 10; i++) chk("golden_tbl", fact8(i), FACT8[i]);

    // Plain sweep 0..5 with an always-ready factorial.
    pulse_start(0, 5);
    wait_done(500);
    chk("t1_count", res_count, 6);
    chk("t1_sum", res_sum, 154);
    chk("t1_xor", res_xor, 8'h64);
    chk("t1_busy", busy, 0);

    // 6..10 under random backpressure.
    rnd_rdy = 1'b1; fix_dly = -1;
    pulse_start(6, 10);
    wait_done(1000);
    chk("t2_sum", res_sum, 640);
    chk("t2_xor", res_xor, 8'h60);
    chk("t2_mis", mismatch, 0);

    // Corrupt the n=7 result; mismatch must be sticky until the next start.
    corrupt_n = 7;
    pulse_start(6, 10);
    wait_done(1000);
    corrupt_n = -1;
    chk("t3_sum", res_sum, 549);
    repeat (5) @(posedge clk);
    #1 chk("t3_mis_sticky", mismatch, GOLDEN);

    // Empty range: done on the next cycle, no requests at all.
    n0 = n_xfers;
    pulse_start(7, 3);
    chk("t4_done", done, 1);
    chk("t4_count", res_count, 0);
    chk("t4_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("t4_no_req", n_xfers - n0, 0);

    // Fixed backpressure: n held for 4 cycles, results delayed 3.
    rnd_rdy = 1'b0; hold_n = 4; fix_dly = 3; n0 = n_xfers;
    pulse_start(2, 4);
    wait_done(500);
    chk("t5_xfers", n_xfers - n0, 3);
    chk("t5_sum", res_sum, 32);

    // Top of the range must not wrap.
    fix_dly = -1; n0 = n_xfers;
    pulse_start(254, 255);
    wait_done(2000);
    chk("t6_xfers", n_xfers - n0, 2);
    chk("t6_count", res_count, 2);
    repeat (4) @(posedge clk);
    #1 chk("t6_no_wrap", n_xfers - n0, 2);

    // Random sweeps, with a stray start that must be ignored while busy.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      f = $urandom_range(0, 12); l = $urandom_range(0, 14);
      pulse_start(f, l);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      if (busy) pulse_start(0, 1);
      wait_done(1500);
    end

    // Reset while waiting on a result, then a clean sweep.
    pulse_start(0, 9);
    for (int i = 0; i < 400 && !(chan_result_rdy && res_count >= 2); i++) begin
      @(posedge clk); #1;
    end
    chk("t7_in_wait", chan_result_rdy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_rdy", chan_result_rdy, 0);
    chk("t7_count", res_count, 0);
    chk("t7_chan_n", chan_n, 0);
    rnd_rdy = 1'b0; fix_dly = 0;
    pulse_start(0, 5);
    wait_done(1000);
    chk("t7_sum", res_sum, 154);
    chk("t7_xor", res_xor, 8'h64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
